watch_mode_ctrl: RTL and testbench

- Front-end controller for the watch display datapath.
- Synchronises and debounces the two active-low push keys, and classifies presses as short, long or chord (both keys long).
- Runs the mode state machine WATCH / SETTING / TIMER.
- Drives registered control strobes (digit select, digit increment, timer start/stop/clear, seconds view) into the time-keeping and hex-digit datapath.

---
 rtl/watch_pkg.sv | 15 +
 rtl/key_conditioner.sv | 66 ++++++
 rtl/watch_mode_ctrl.sv | 137 +++++++++++++
 tb/tb_watch_mode_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types for the watch display front-end controller.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_WATCH   = 2'd0,
    MODE_SETTING = 2'd1,
    MODE_TIMER   = 2'd2
  } mode_t;

  typedef struct packed {
    logic short_p;
    logic long_p;
  } key_evt_t;

endpackage

// File: rtl/key_conditioner.sv
// One push key: inversion, 2-FF synchroniser, debounce filter and saturating hold counter.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 200_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic hold_long,
  output logic release_edge
);

  localparam int unsigned DbW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned HoldW = $clog2(LONG_CYC + 1);

  logic             sync_meta_q, sync_q;
  logic             deb_q, deb_d, deb_prev_q;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      deb_q       <= 1'b0;
      deb_prev_q  <= 1'b0;
      db_cnt_q    <= '0;
      hold_q      <= '0;
    end else begin
      sync_meta_q <= ~key_n;
      sync_q      <= sync_meta_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      db_cnt_q    <= db_cnt_d;
      hold_q      <= hold_d;
    end
  end

  // Counter only runs while the synchronised level disagrees with the debounced one,
  // so any bounce back to the old level restarts the qualification window.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync_q != deb_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
        deb_d = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  always_comb begin
    hold_d = '0;
    if (deb_q) begin
      hold_d = (hold_q == HoldW'(LONG_CYC)) ? hold_q : hold_q + HoldW'(1);
    end
  end

  // hold_q is still valid on the release-edge cycle; it clears one cycle later.
  assign pressed      = deb_q;
  assign hold_long    = (hold_q == HoldW'(LONG_CYC));
  assign release_edge = deb_prev_q & ~deb_q;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch front end: classifies key gestures and runs the WATCH/SETTING/TIMER mode machine.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 200_000_000,
  parameter int unsigned NUM_DIGITS   = 4,
  localparam int unsigned SelW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_one_n,
  input  logic            key_two_n,
  output mode_t           mode,
  output logic [SelW-1:0] digit_sel,
  output logic            inc_digit,
  output logic            show_seconds,
  output logic            timer_run_toggle,
  output logic            timer_clear
);

  logic     p1, p2, hl1, hl2, rel1, rel2;
  logic     hl1_q, hl2_q, taint_q, taint_d, taint, chord;
  key_evt_t evt1, evt2;

  mode_t            mode_q, mode_d;
  logic [SelW-1:0]  sel_q, sel_d;
  logic             show_q, show_d;
  logic             inc_q, inc_d, tog_q, tog_d, clr_q, clr_d;

  key_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .LONG_CYC(LONG_CYC)) u_key_one (
    .clk(clk), .rst(rst), .key_n(key_one_n),
    .pressed(p1), .hold_long(hl1), .release_edge(rel1)
  );

  key_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .LONG_CYC(LONG_CYC)) u_key_two (
    .clk(clk), .rst(rst), .key_n(key_two_n),
    .pressed(p2), .hold_long(hl2), .release_edge(rel2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hl1_q   <= 1'b0;
      hl2_q   <= 1'b0;
      taint_q <= 1'b0;
    end else begin
      hl1_q   <= hl1;
      hl2_q   <= hl2;
      taint_q <= taint_d;
    end
  end

  // Any overlap of the two keys taints both presses until both are released.
  always_comb begin
    taint        = taint_q | (p1 & p2);
    taint_d      = taint & (p1 | p2);
    chord        = hl1 & hl2 & ~(hl1_q & hl2_q);
    evt1.long_p  = hl1 & ~hl1_q & ~p2 & ~taint;
    evt2.long_p  = hl2 & ~hl2_q & ~p1 & ~taint;
    evt1.short_p = rel1 & ~hl1 & ~taint;
    evt2.short_p = rel2 & ~hl2 & ~taint;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_WATCH;
      sel_q  <= '0;
      show_q <= 1'b0;
      inc_q  <= 1'b0;
      tog_q  <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
      show_q <= show_d;
      inc_q  <= inc_d;
      tog_q  <= tog_d;
      clr_q  <= clr_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_WATCH: begin
        if (evt1.short_p)  mode_d = MODE_SETTING;
        else if (chord)    mode_d = MODE_TIMER;
      end
      MODE_SETTING: begin
        if (evt1.long_p || chord) mode_d = MODE_WATCH;
      end
      MODE_TIMER: begin
        if (chord) mode_d = MODE_WATCH;
      end
      default: mode_d = MODE_WATCH;
    endcase
  end

  always_comb begin
    sel_d  = sel_q;
    show_d = show_q;
    inc_d  = 1'b0;
    tog_d  = 1'b0;
    clr_d  = 1'b0;
    case (mode_q)
      MODE_WATCH: begin
        if (evt1.short_p)     sel_d  = '0;
        else if (evt2.long_p) show_d = ~show_q;
      end
      MODE_SETTING: begin
        if (evt1.short_p) begin
          sel_d = (sel_q == SelW'(NUM_DIGITS - 1)) ? '0 : sel_q + SelW'(1);
        end else if (evt2.short_p) begin
          inc_d = 1'b1;
        end else if (evt1.long_p) begin
          show_d = 1'b0;
        end
      end
      MODE_TIMER: begin
        if (evt1.short_p)      tog_d = 1'b1;
        else if (evt2.short_p) clr_d = 1'b1;
      end
      default: begin
        sel_d  = '0;
        show_d = 1'b0;
      end
    endcase
  end

  assign mode             = mode_q;
  assign digit_sel        = sel_q;
  assign show_seconds     = show_q;
  assign inc_digit        = inc_q;
  assign timer_run_toggle = tog_q;
  assign timer_clear      = clr_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed and randomized gesture bench for watch_mode_ctrl against an event-level mode model.
module tb_watch_mode_ctrl;
  import watch_pkg::*;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam int unsigned ND   = 4;

  typedef enum int {EvS1, EvS2, EvL1, EvL2, EvChord, EvNone} ev_e;

  logic       clk = 1'b0;
  logic       rst;
  logic       k1n, k2n;
  mode_t      mode;
  logic [1:0] digit_sel;
  logic       inc_digit, show_seconds, timer_run_toggle, timer_clear;

  int total = 0;
  int bad   = 0;
  int n_inc = 0, n_tog = 0, n_clr = 0;
  int e_inc = 0, e_tog = 0, e_clr = 0;
  int e_sel = 0;
  bit e_show = 1'b0;
  mode_t e_mode = MODE_WATCH;
  logic inc_prev = 1'b0, tog_prev = 1'b0, clr_prev = 1'b0;

  watch_mode_ctrl #(.DEBOUNCE_CYC(DEB), .LONG_CYC(LONG), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .key_one_n(k1n), .key_two_n(k2n),
    .mode(mode), .digit_sel(digit_sel), .inc_digit(inc_digit),
    .show_seconds(show_seconds), .timer_run_toggle(timer_run_toggle),
    .timer_clear(timer_clear)
  );

  always #5 clk = ~clk;

  // Pulse monitor: at most one strobe per cycle, each exactly one cycle wide.
  always @(negedge clk) begin
    total++;
    assert (int'(inc_digit) + int'(timer_run_toggle) + int'(timer_clear) <= 1) else begin
      bad++;
      $error("FAIL multi_pulse: got inc=%0b tog=%0b clr=%0b want at most one",
             inc_digit, timer_run_toggle, timer_clear);
    end
    total++;
    assert (!((inc_digit && inc_prev) || (timer_run_toggle && tog_prev) ||
              (timer_clear && clr_prev))) else begin
      bad++;
      $error("FAIL pulse_width: got a strobe high two cycles running want single cycle");
    end
    n_inc += int'(inc_digit);
    n_tog += int'(timer_run_toggle);
    n_clr += int'(timer_clear);
    inc_prev = inc_digit;
    tog_prev = timer_run_toggle;
    clr_prev = timer_clear;
  end

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mode"}, int'(mode), int'(e_mode));
    chk({tag, ".sel"},  int'(digit_sel), e_sel);
    chk({tag, ".show"}, int'(show_seconds), int'(e_show));
    chk({tag, ".inc"},  n_inc, e_inc);
    chk({tag, ".tog"},  n_tog, e_tog);
    chk({tag, ".clr"},  n_clr, e_clr);
  endtask

  // Mode rules applied per classified gesture.
  task automatic model(input ev_e ev);
    case (e_mode)
      MODE_WATCH: begin
        if (ev == EvS1) begin
          e_mode = MODE_SETTING;
          e_sel  = 0;
        end else if (ev == EvL2) begin
          e_show = !e_show;
        end else if (ev == EvChord) begin
          e_mode = MODE_TIMER;
        end
      end
      MODE_SETTING: begin
        if (ev == EvS1) e_sel = (e_sel + 1) % ND;
        else if (ev == EvS2) e_inc++;
        else if (ev == EvL1) begin
          e_mode = MODE_WATCH;
          e_show = 1'b0;
        end else if (ev == EvChord) e_mode = MODE_WATCH;
      end
      default: begin
        if (ev == EvS1) e_tog++;
        else if (ev == EvS2) e_clr++;
        else if (ev == EvChord) e_mode = MODE_WATCH;
      end
    endcase
  endtask

  // Clean press of the selected keys for n cycles, then gap idle cycles.
  task automatic gesture(input bit use1, input bit use2, input int n, input int gap,
                         input string tag);
    ev_e ev;
    @(negedge clk);
    k1n = !use1;
    k2n = !use2;
    repeat (n) @(negedge clk);
    k1n = 1'b1;
    k2n = 1'b1;
    repeat (gap) @(negedge clk);
    if (use1 && use2) ev = (n >= int'(LONG)) ? EvChord : EvNone;
    else if (use1)    ev = (n >= int'(LONG)) ? EvL1 : EvS1;
    else              ev = (n >= int'(LONG)) ? EvL2 : EvS2;
    model(ev);
    check_all(tag);
  endtask

  initial begin
    int kind, n;
    rst = 1'b1;
    k1n = 1'b1;
    k2n = 1'b1;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Bounce shorter than the debounce window must be ignored.
    for (int i = 0; i < 6; i++) begin
      k1n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    k1n = 1'b1;
    repeat (15) @(negedge clk);
    model(EvNone);
    check_all("bounce");

    gesture(1'b1, 1'b0, 10, 12, "enter_setting");
    for (int i = 0; i < 5; i++) gesture(1'b1, 1'b0, 8, 12, "sel_step");
    for (int i = 0; i < 3; i++) gesture(1'b0, 1'b1, 8, 12, "inc_step");

    // Long key 1: mode flips exactly one cycle after the hold count reaches LONG.
    @(negedge clk);
    k1n = 1'b0;
    repeat (DEB + 2 + LONG) @(posedge clk);
    @(negedge clk);
    chk("long1_before", int'(mode), int'(MODE_SETTING));
    @(negedge clk);
    chk("long1_after", int'(mode), int'(MODE_WATCH));
    repeat (3) @(negedge clk);
    k1n = 1'b1;
    repeat (12) @(negedge clk);
    model(EvL1);
    check_all("long1_release");

    gesture(1'b1, 1'b1, 25, 12, "chord_to_timer");
    gesture(1'b1, 1'b1, 25, 12, "chord_to_watch");
    gesture(1'b1, 1'b1, 25, 12, "chord_again");
    gesture(1'b1, 1'b0, 8, 12, "timer_toggle");
    gesture(1'b0, 1'b1, 8, 12, "timer_clear");
    gesture(1'b0, 1'b1, 30, 12, "timer_long2");
    gesture(1'b1, 1'b0, LONG - 1, 12, "timer_short_edge");
    gesture(1'b1, 1'b1, 10, 12, "tainted_short");

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(5, 0));
      if (kind < 2 || kind == 4) n = int'($urandom_range(LONG - 2, 6));
      else n = int'($urandom_range(LONG + 15, LONG + 2));
      case (kind)
        0, 2:    gesture(1'b1, 1'b0, n, 12 + int'($urandom_range(4, 0)), "rand_k1");
        1, 3:    gesture(1'b0, 1'b1, n, 12 + int'($urandom_range(4, 0)), "rand_k2");
        default: gesture(1'b1, 1'b1, n, 12 + int'($urandom_range(4, 0)), "rand_both");
      endcase
    end

    // Steer into SETTING, then reset in the middle of a key-2 hold.
    if (e_mode == MODE_TIMER) gesture(1'b1, 1'b1, 25, 12, "to_watch");
    if (e_mode == MODE_WATCH) gesture(1'b1, 1'b0, 8, 12, "to_setting");
    @(negedge clk);
    k2n = 1'b0;
    repeat (DEB + 2 + 15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    e_mode = MODE_WATCH;
    e_sel  = 0;
    e_show = 1'b0;
    chk("rst_mid.mode", int'(mode), int'(e_mode));
    chk("rst_mid.sel",  int'(digit_sel), e_sel);
    chk("rst_mid.show", int'(show_seconds), int'(e_show));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (DEB + 2 + LONG + 6) @(negedge clk);
    chk("rst_held.show", int'(show_seconds), 1);
    k2n = 1'b1;
    repeat (12) @(negedge clk);
    model(EvL2);
    check_all("rst_long2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
